// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable async serial receiver with parity/framing checks and ready/valid output
module uart_rx_cfg #(
  parameter int unsigned BAUD_DIV  = 104,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;
  localparam logic [15:0] HALF   = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL   = 16'(BAUD_DIV - 1);
  localparam logic [3:0]  LAST_D = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LAST_S = 4'(STOP_BITS - 1);
  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic [15:0]          cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic                 pe_q, pe_d, fe_q, fe_d;
  logic                 valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic                 rx_s, tick, load, fe_now;
  assign rx_s   = sync_q[1];
  assign tick   = cnt_q == (state_q == START ? HALF : FULL);
  assign fe_now = fe_q | ~rx_s;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    load    = 1'b0;
    case (state_q)
      IDLE:  if (!rx_s) state_d = START;
      START: if (tick) begin
        state_d = rx_s ? IDLE : DATA;
        idx_d   = '0;
        pe_d    = 1'b0;
        fe_d    = 1'b0;
      end
      DATA:  if (tick) begin
        sh_d    = {rx_s, sh_q[DATA_BITS-1:1]};
        idx_d   = idx_q == LAST_D ? 4'd0 : idx_q + 4'd1;
        state_d = idx_q != LAST_D ? DATA : PARITY != 0 ? PAR : STOP;
      end
      PAR:   if (tick) begin
        pe_d    = rx_s != (PARITY == 1 ? ~^sh_q : ^sh_q);
        state_d = STOP;
      end
      STOP:  if (tick) begin
        fe_d  = fe_now;
        idx_d = idx_q + 4'd1;
        if (idx_q == LAST_S) begin
          load    = 1'b1;
          state_d = fe_now ? BRK : IDLE;
        end
      end
      BRK:   if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d   = (state_d != state_q || tick) ? 16'd0 : cnt_q + 16'd1;
    // a new word always wins over an unaccepted one; overrun records the loss
    data_d  = load ? sh_q : data_q;
    perr_d  = load ? pe_q : perr_q;
    ferr_d  = load ? fe_now : ferr_q;
    valid_d = load | (valid_q & ~ready);
    ovr_d   = load ? (valid_q & ~ready) : (valid_q & ready) ? 1'b0 : ovr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], rx};
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
  assign data_out   = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = state_q != IDLE;
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised asynchronous serial receiver. It is the successor to the fixed 8N1 receiver, with configurable data width, parity, stop bits and baud divisor. It adds false-start rejection, parity and framing error reporting, and a ready/valid output with overrun detection. It sits between the board RX pin and any byte-stream consumer, such as a FIFO or command decoder.

Parameters:
BAUD_DIV, 104, clock cycles per bit (12 MHz / 115200); legal range 8..65535
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
rx  in  1  asynchronous serial input, idle high
data_out  out  DATA_BITS  received word, LSB = first bit on the line
valid  out  1  data_out/status hold a word not yet accepted
ready  in  1  consumer accepts the word when valid && ready
parity_err  out  1  parity mismatch for the word in data_out
frame_err  out  1  a stop-bit sample was 0 for the word in data_out
overrun  out  1  at least one earlier word was overwritten before acceptance
busy  out  1  FSM not in IDLE

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is synchronous and active high (rst).
- Reset values: data_out=0, valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, synchroniser flops=1.
- Input path: rx passes through a 2-flop synchroniser to give rx_s. All decisions use rx_s only.
- Bit timer: a 16-bit counter is cleared on every state entry. A tick is the cycle in which the counter equals the target.
  - START target: BAUD_DIV/2 - 1 (integer division).
  - All other states: BAUD_DIV - 1.
- FSM states and transitions:
  - IDLE: when rx_s==0, go to START.
  - START: at tick, if rx_s==1 it is a false start: go to IDLE with no output and no flags. Otherwise go to DATA with bit index=0.
  - DATA: at each tick, shift rx_s in LSB-first. After DATA_BITS samples go to PARITY (PARITY!=0) or STOP.
  - PARITY: at tick, compare rx_s with the expected bit.
    - Odd: expected = ~^data.
    - Even: expected = ^data.
  - STOP: sample at tick STOP_BITS times. A 0 on any sample marks a frame error.
  - After the final stop sample: if the frame was good go to IDLE; on a frame error go to BREAK.
  - BREAK: stay until rx_s==1, then go to IDLE. A held-low break line must never produce back-to-back words.
- Output load: occurs on the cycle after the final stop sample, so valid rises 1 clk after that sample. The load writes data_out, parity_err and frame_err.
- Frames with errors are still delivered: valid=1 with the error flags set.
- Handshake: while valid && !ready, data_out and all flags hold stable. valid falls the cycle after valid && ready, unless a new load occurs in that same cycle.
- Load with valid && ready in the same cycle: the new word replaces the old one, valid stays 1, overrun=0.
- Load with valid && !ready: the new word overwrites the old one, valid stays 1, overrun=1.
- overrun is sticky per word: it clears only when a word is accepted, unless set again by the same-cycle load rule above.
- Total frame length in bit periods = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS. The FSM re-enters IDLE half a bit into the last stop bit, giving half-bit margin for sender clock skew.
- Reset mid-frame: the partial frame is discarded, no valid is produced, and reception restarts at IDLE on the next falling edge after rst deasserts.

Test Plan:
- BAUD_DIV=16, 8N1, send 0x55 with ready=1 -> valid pulses 1 cycle, data_out=0x55, all flags 0; valid rises 1 clk after the stop-bit mid-sample.
- PARITY=2, send 0xA3 with parity bit 0 -> parity_err=0. Resend with parity bit 1 -> data_out=0xA3, parity_err=1.
- Send 0x3C with the stop bit driven 0, then hold rx low for 40 bit times -> exactly one word, data_out=0x3C, frame_err=1; no further valid until rx returns high and a new start arrives.
- 4-cycle low glitch on idle rx (BAUD_DIV=16) -> no valid, busy returns to 0 within 10 cycles.
- ready=0, send 0x11 then 0x22 -> data_out=0x22, overrun=1. Raise ready for 1 cycle -> valid=0, overrun=0.
- DATA_BITS=7, STOP_BITS=2, send 0x7F; assert rst for 1 cycle at data bit 3 of a second frame -> first word 0x7F delivered; second frame produces no valid; a subsequent frame 0x01 is received correctly.
